seven_seg_scan_reader: RTL and testbench

Receive-side companion to the lock's multiplexed display driver. It samples the active-low anode (`an`) and segment (`seg`) buses that the driver scans at 400 Hz, and filters out transition ghosting. It decodes each settled segment pattern back into the 5-bit display symbol code and presents a complete 4-digit frame with a one-cycle valid pulse. It sits on the bench or on a loop-back path for self-check, and its outputs feed comparison logic or the state machine test harness.

---
 rtl/seven_seg_scan_reader_if.sv | 31 +++
 rtl/seven_seg_scan_reader.sv | 176 +++++++++++++++++
 tb/tb_seven_seg_scan_reader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_reader_if.sv
// Bus between a multiplexed 7-segment driver (or a bench) and the scan reader.
// The master drives the scanned anode/segment pins; the reader returns decoded frames.
interface seven_seg_scan_reader_if;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [19:0] digits;
    logic        frame_valid;
    logic        frame_changed;
    logic        dec_err;
    logic        stale;

    modport master (
        output an,
        output seg,
        input  digits,
        input  frame_valid,
        input  frame_changed,
        input  dec_err,
        input  stale
    );

    modport slave (
        input  an,
        input  seg,
        output digits,
        output frame_valid,
        output frame_changed,
        output dec_err,
        output stale
    );
endinterface

// File: rtl/seven_seg_scan_reader.sv
// Samples a scanned active-low 4-digit 7-segment display, rejects ghosting with a
// dwell filter, decodes each settled digit back to its symbol code and emits frames.
module seven_seg_scan_reader #(
    parameter int SETTLE  = 1024,
    parameter int TIMEOUT = 2000000
) (
    input  logic                  clk_100Mhz,
    input  logic                  RST_n,
    seven_seg_scan_reader_if.slave bus
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 2);
    localparam logic [15:0] STAB_MAX    = 16'hFFFF;
    localparam logic [23:0] TMO_MAX     = 24'(TIMEOUT);
    localparam logic [4:0]  CODE_BLANK  = 5'd19;
    localparam logic [4:0]  CODE_BAD    = 5'd31;

    // Maps an active-high gfedcba pattern to its symbol code; S shares 6D with 5.
    function automatic logic [4:0] decode_pattern(input logic [6:0] pat);
        logic [4:0] code;
        case (pat)
            7'h3F:   code = 5'd0;
            7'h06:   code = 5'd1;
            7'h5B:   code = 5'd2;
            7'h4F:   code = 5'd3;
            7'h66:   code = 5'd4;
            7'h6D:   code = 5'd5;
            7'h7D:   code = 5'd6;
            7'h07:   code = 5'd7;
            7'h7F:   code = 5'd8;
            7'h6F:   code = 5'd9;
            7'h77:   code = 5'd10;
            7'h71:   code = 5'd11;
            7'h3D:   code = 5'd12;
            7'h30:   code = 5'd13;
            7'h38:   code = 5'd14;
            7'h5C:   code = 5'd15;
            7'h73:   code = 5'd16;
            7'h40:   code = 5'd18;
            7'h00:   code = 5'd19;
            default: code = 5'd31;
        endcase
        return code;
    endfunction

    logic [7:0]       an_r;
    logic [6:0]       seg_r;
    logic [7:0]       prev_an_r;
    logic [6:0]       prev_seg_r;
    logic [15:0]      stab_cnt_r;
    logic [23:0]      tmo_cnt_r;
    logic [3:0]       seen_r;
    logic [3:0][4:0]  digit_r;
    logic [19:0]      digits_r;
    logic             frame_valid_r;
    logic             frame_changed_r;
    logic             dec_err_r;
    logic             stale_r;

    logic             sel_valid_s;
    logic [1:0]       idx_s;
    logic             pair_same_s;
    logic             accept_s;
    logic [4:0]       code_s;
    logic [15:0]      stab_next_s;
    logic [23:0]      tmo_next_s;
    logic [3:0]       seen_set_s;
    logic [3:0]       seen_next_s;
    logic [3:0][4:0]  digit_next_s;
    logic             complete_s;

    // Anode decode: exactly one of the low four anodes active, upper four idle.
    always_comb begin
        sel_valid_s = 1'b0;
        idx_s       = 2'd0;
        if (an_r[7:4] == 4'hF) begin
            case (an_r[3:0])
                4'b1110: begin sel_valid_s = 1'b1; idx_s = 2'd0; end
                4'b1101: begin sel_valid_s = 1'b1; idx_s = 2'd1; end
                4'b1011: begin sel_valid_s = 1'b1; idx_s = 2'd2; end
                4'b0111: begin sel_valid_s = 1'b1; idx_s = 2'd3; end
                default: begin sel_valid_s = 1'b0; idx_s = 2'd0; end
            endcase
        end else begin
            sel_valid_s = 1'b0;
            idx_s       = 2'd0;
        end
    end

    // Dwell filter: the counter saturates so a long dwell is accepted only once.
    always_comb begin
        pair_same_s = (an_r == prev_an_r) && (seg_r == prev_seg_r);
        accept_s    = sel_valid_s && pair_same_s && (stab_cnt_r == SETTLE_LAST);
        code_s      = decode_pattern(~seg_r);
        if (!(sel_valid_s && pair_same_s)) begin
            stab_next_s = 16'd0;
        end else if (stab_cnt_r != STAB_MAX) begin
            stab_next_s = stab_cnt_r + 16'd1;
        end else begin
            stab_next_s = stab_cnt_r;
        end
        if (accept_s) begin
            tmo_next_s = 24'd0;
        end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_next_s = tmo_cnt_r + 24'd1;
        end else begin
            tmo_next_s = tmo_cnt_r;
        end
    end

    // Digit capture and frame assembly, including the digit accepted this edge.
    always_comb begin
        digit_next_s = digit_r;
        seen_set_s   = seen_r;
        seen_next_s  = seen_r;
        complete_s   = 1'b0;
        if (accept_s) begin
            digit_next_s[idx_s] = code_s;
            seen_set_s          = seen_r | (4'b0001 << idx_s);
            if (seen_set_s == 4'hF) begin
                complete_s  = 1'b1;
                seen_next_s = 4'h0;
            end else begin
                complete_s  = 1'b0;
                seen_next_s = seen_set_s;
            end
        end else begin
            digit_next_s = digit_r;
            seen_next_s  = seen_r;
        end
    end

    // All state and registered outputs; reset wins over every other event.
    always_ff @(posedge clk_100Mhz) begin
        if (!RST_n) begin
            an_r            <= 8'hFF;
            seg_r           <= 7'h7F;
            prev_an_r       <= 8'hFF;
            prev_seg_r      <= 7'h7F;
            stab_cnt_r      <= 16'd0;
            tmo_cnt_r       <= 24'd0;
            seen_r          <= 4'h0;
            digit_r         <= {4{CODE_BLANK}};
            digits_r        <= {4{CODE_BLANK}};
            frame_valid_r   <= 1'b0;
            frame_changed_r <= 1'b0;
            dec_err_r       <= 1'b0;
            stale_r         <= 1'b0;
        end else begin
            an_r            <= bus.an;
            seg_r           <= bus.seg;
            prev_an_r       <= an_r;
            prev_seg_r      <= seg_r;
            stab_cnt_r      <= stab_next_s;
            tmo_cnt_r       <= tmo_next_s;
            seen_r          <= seen_next_s;
            digit_r         <= digit_next_s;
            frame_valid_r   <= complete_s;
            frame_changed_r <= complete_s && (digit_next_s != digits_r);
            dec_err_r       <= accept_s && (code_s == CODE_BAD);
            stale_r         <= (tmo_next_s == TMO_MAX);
            if (complete_s) begin
                digits_r <= digit_next_s;
            end else begin
                digits_r <= digits_r;
            end
        end
    end

    assign bus.digits        = digits_r;
    assign bus.frame_valid   = frame_valid_r;
    assign bus.frame_changed = frame_changed_r;
    assign bus.dec_err       = dec_err_r;
    assign bus.stale         = stale_r;

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Scoreboard bench for seven_seg_scan_reader: expected frames are queued as scans
// are driven and compared when frame_valid pulses.
module tb_seven_seg_scan_reader;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seven_seg_scan_reader_if bus ();

    seven_seg_scan_reader #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_100Mhz (clk),
        .RST_n      (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int unsigned   checks   = 0;
    int unsigned   errors   = 0;
    int unsigned   fv_count = 0;
    int unsigned   de_count = 0;
    logic [20:0]   exp_q[$];
    logic [19:0]   model_prev = 20'h9CE73;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Active-low pin pattern for a symbol code; 31 stands for "segment a only".
    function automatic logic [6:0] seg_of(input logic [4:0] code);
        logic [6:0] p;
        case (code)
            5'd0:  p = 7'h3F;  5'd1:  p = 7'h06;  5'd2:  p = 7'h5B;  5'd3:  p = 7'h4F;
            5'd4:  p = 7'h66;  5'd5:  p = 7'h6D;  5'd6:  p = 7'h7D;  5'd7:  p = 7'h07;
            5'd8:  p = 7'h7F;  5'd9:  p = 7'h6F;  5'd10: p = 7'h77;  5'd11: p = 7'h71;
            5'd12: p = 7'h3D;  5'd13: p = 7'h30;  5'd14: p = 7'h38;  5'd15: p = 7'h5C;
            5'd16: p = 7'h73;  5'd18: p = 7'h40;  5'd19: p = 7'h00;
            default: p = 7'h01;
        endcase
        return ~p;
    endfunction

    // Frame monitor: pops the scoreboard on every frame_valid pulse.
    logic prev_fv = 1'b0;
    always @(negedge clk) begin
        if (bus.dec_err) de_count++;
        if (bus.frame_valid) begin
            fv_count++;
            check("fv_width", {31'd0, prev_fv}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_frame", {12'd0, bus.digits}, 32'hFFFFFFFF);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("frame_digits", {12'd0, bus.digits}, {12'd0, e[19:0]});
                check("frame_changed", {31'd0, bus.frame_changed}, {31'd0, e[20]});
            end
        end
        prev_fv <= bus.frame_valid;
    end

    task automatic drive(input logic [7:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] an_of(input int i);
        logic [7:0] a;
        a    = 8'hFF;
        a[i] = 1'b0;
        return a;
    endfunction

    task automatic push_frame(input logic [19:0] f);
        exp_q.push_back({(f != model_prev), f});
        model_prev = f;
    endtask

    // Scans d3..d0, optionally with invalid-select gaps and transitional pairs.
    task automatic scan(input logic [4:0] c3, c2, c1, c0, input bit ghost);
        logic [4:0] cs[4];
        logic [6:0] prev_seg;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        push_frame({c3, c2, c1, c0});
        prev_seg = bus.seg;
        for (int i = 3; i >= 0; i--) begin
            if (ghost) begin
                drive(8'hF3, prev_seg, 20);
                drive(an_of(i), prev_seg, 3);
            end
            drive(an_of(i), seg_of(cs[i]), 10);
            prev_seg = seg_of(cs[i]);
        end
        drive(8'hFF, prev_seg, 4);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) begin
            bus.an  = 8'($urandom);
            bus.seg = 7'($urandom);
            @(negedge clk);
        end
        model_prev = 20'h9CE73;
    endtask

    task automatic wait_fv(input int max, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (bus.frame_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned base_fv;
        int unsigned base_de;
        bus.an  = 8'hFF;
        bus.seg = 7'h7F;

        // Reset with random pins
        do_reset(3);
        check("rst_digits", {12'd0, bus.digits}, 32'h0009CE73);
        check("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
        check("rst_fc", {31'd0, bus.frame_changed}, 32'd0);
        check("rst_de", {31'd0, bus.dec_err}, 32'd0);
        check("rst_stale", {31'd0, bus.stale}, 32'd0);
        rst_n = 1'b1;
        drive(8'hFF, 7'h7F, SETTLE + 4);

        // "0059" twice
        scan(5'd0, 5'd0, 5'd5, 5'd9, 1'b0);
        check("scan0059_pins", {25'd0, seg_of(5'd5)}, 32'h12);
        scan(5'd0, 5'd0, 5'd5, 5'd9, 1'b0);

        // Ghosting
        scan(5'd1, 5'd2, 5'd3, 5'd4, 1'b1);
        scan(5'd10, 5'd18, 5'd13, 5'd19, 1'b1);

        // Unknown pattern on digit2
        base_de = de_count;
        scan(5'd15, 5'd31, 5'd11, 5'd12, 1'b0);
        check("dec_err_pulses", de_count - base_de, 32'd1);

        // Stale
        push_frame({5'd8, 5'd7, 5'd6, 5'd5});
        drive(an_of(3), seg_of(5'd8), 10);
        drive(an_of(2), seg_of(5'd7), 10);
        drive(an_of(1), seg_of(5'd6), 10);
        bus.an  = an_of(0);
        bus.seg = seg_of(5'd5);
        wait_fv(20, n);
        check("stale_fv_seen", (n > 0) ? 32'd1 : 32'd0, 32'd1);
        bus.an = 8'hFF;
        repeat (TIMEOUT - 1) @(negedge clk);
        check("stale_early", {31'd0, bus.stale}, 32'd0);
        @(negedge clk);
        check("stale_rise", {31'd0, bus.stale}, 32'd1);
        bus.an  = an_of(3);
        bus.seg = seg_of(5'd1);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!bus.stale) begin
                n = i;
                break;
            end
        end
        check("stale_fall_lat", n, SETTLE + 1);
        drive(8'hFF, 7'h7F, 5);

        // Reset mid-frame
        do_reset(2);
        rst_n = 1'b1;
        drive(an_of(0), seg_of(5'd14), 10);
        drive(an_of(1), seg_of(5'd0), 10);
        do_reset(2);
        rst_n = 1'b1;
        check("mid_rst_digits", {12'd0, bus.digits}, 32'h0009CE73);
        base_fv = fv_count;
        drive(an_of(2), seg_of(5'd12), 10);
        drive(an_of(3), seg_of(5'd16), 10);
        drive(an_of(0), seg_of(5'd14), 10);
        check("mid_rst_no_frame", fv_count - base_fv, 32'd0);
        push_frame({5'd16, 5'd12, 5'd0, 5'd14});
        drive(an_of(1), seg_of(5'd0), 10);
        drive(8'hFF, 7'h7F, 6);
        check("mid_rst_one_frame", fv_count - base_fv, 32'd1);

        check("pending_frames", exp_q.size(), 32'd0);
        check("frames_total", fv_count, 32'd7);
        check("dec_err_total", de_count, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
